// File: rtl/gearbox_pkg.sv
// Shared constants and helpers for the 128<->132 bit gearboxes.
// Widths are fixed; the residue counter n counts pending 4-bit nibbles.
package gearbox_pkg;
   localparam int IN_W      = 128;
   localparam int OUT_W     = 132;
   localparam int NIB_W     = 4;
   localparam int GROUP_IN  = 33;
   localparam int GROUP_OUT = 32;
   localparam int PH_W      = 6;

   typedef logic [PH_W-1:0] phase_t;

   // Number of residue bits held when n nibbles are pending.
   function automatic logic [7:0] nib_bits(input phase_t n);
      return {n, 2'b00};
   endfunction
endpackage

// File: rtl/gb_nibble_slicer.sv
// Combinational variable-width slice: joins the pending residue with a new
// input word and splits the result into the next output word and residue.
module gb_nibble_slicer
   import gearbox_pkg::*;
(
   input  logic [IN_W-1:0]  res,
   input  phase_t           n,
   input  logic [IN_W-1:0]  din,
   output logic [OUT_W-1:0] nxt_dout,
   output logic [IN_W-1:0]  nxt_res
);
   localparam int SW = IN_W + OUT_W;

   logic [SW-1:0] stream;

   // res is left-aligned and zero below its valid bits, so the shifted
   // input can simply be OR-ed in directly after the pending nibbles.
   assign stream   = {res, {OUT_W{1'b0}}} | ({din, {OUT_W{1'b0}}} >> nib_bits(n));
   assign nxt_dout = stream[SW-1 -: OUT_W];
   assign nxt_res  = stream[IN_W-1:0];
endmodule

// File: rtl/gearbox_128_132.sv
// Re-slices an MSB-first stream of 128-bit words into 132-bit words.
// Every 33 accepted inputs yield 32 outputs; phase reports pending nibbles.
module gearbox_128_132
   import gearbox_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             din_valid,
   input  logic [IN_W-1:0]  din,
   output logic             din_ready,
   input  logic             dout_ready,
   output logic             dout_valid,
   output logic [OUT_W-1:0] dout,
   output logic [PH_W-1:0]  phase
);
   logic [IN_W-1:0]  res;
   phase_t           n;
   logic             accept;
   logic             xfer;
   logic [OUT_W-1:0] slc_dout;
   logic [IN_W-1:0]  slc_res;

   // Handshake: a beat moves when valid && ready on a rising edge; ready never
   // depends on valid, and valid/data hold steady until the beat moves.
   assign din_ready = (n == '0) || !dout_valid || dout_ready;
   assign accept    = din_valid && din_ready;
   assign xfer      = dout_valid && dout_ready;
   assign phase     = n;

   gb_nibble_slicer u_slicer (
      .res      (res),
      .n        (n),
      .din      (din),
      .nxt_dout (slc_dout),
      .nxt_res  (slc_res)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         n          <= '0;
         res        <= '0;
         dout       <= '0;
         dout_valid <= 1'b0;
      end else if (accept && (n == '0)) begin
         // First word of a group only fills the residue.
         res <= din;
         n   <= phase_t'(IN_W / NIB_W);
         if (xfer) dout_valid <= 1'b0;
      end else if (accept) begin
         dout       <= slc_dout;
         dout_valid <= 1'b1;
         res        <= slc_res;
         n          <= n - phase_t'(1);
      end else if (xfer) begin
         dout_valid <= 1'b0;
      end
   end
endmodule
